base_mem_mrp: RTL and testbench



---
 rtl/base_mem_mrp_if.sv | 20 ++
 rtl/base_mem_mrp.sv | 118 +++++++++++
 tb/tb_base_mem_mrp.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/base_mem_mrp_if.sv
`timescale 1ns/1ps
// Write/read bus of base_mem_mrp: one lane-masked write port plus nrd read ports.
interface base_mem_mrp_if #(
  parameter int width      = 8,
  parameter int addr_width = 4,
  parameter int lanes      = 1,
  parameter int nrd        = 2
);
  logic                      we;
  logic [addr_width-1:0]     wa;
  logic [width-1:0]          wd;
  logic [lanes-1:0]          wbe;
  logic [nrd-1:0]            re;
  logic [nrd*addr_width-1:0] ra;
  logic [nrd*width-1:0]      rd;
  logic [nrd-1:0]            rv;

  modport master (output we, wa, wd, wbe, re, ra, input rd, rv);
  modport slave  (input we, wa, wd, wbe, re, ra, output rd, rv);
endinterface

// File: rtl/base_mem_mrp.sv
`timescale 1ns/1ps
// Shared table: 1 lane-masked write port, nrd read ports, rlat-cycle pipelined reads, hw init fill.
// No backpressure: one read per port per cycle; writes/reads are ignored while init_busy is high.
module base_mem_mrp #(
  parameter int               width      = 8,
  parameter int               addr_width = 4,
  parameter int               depth      = 2**addr_width,
  parameter int               lanes      = 1,
  parameter int               nrd        = 2,
  parameter int               rlat       = 1,
  parameter int               bypass     = 0,
  parameter logic [width-1:0] init_value = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  output logic          init_busy,
  base_mem_mrp_if.slave bus
);
  localparam int LW = width / lanes;
  localparam logic [addr_width:0]   DEPTH_L = (addr_width + 1)'(depth);
  localparam logic [addr_width-1:0] IC_LAST = addr_width'(depth - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state, state_nxt;
  logic [addr_width-1:0] ic, ic_nxt;
  logic [width-1:0]      ram [depth];
  logic                  run;
  logic                  wr_ok;
  logic [addr_width-1:0] ra_a [nrd];
  logic [width-1:0]      rdat [nrd];
  logic [nrd-1:0]        pv [rlat];
  logic [width-1:0]      pd [rlat][nrd];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      ic    <= '0;
    end else begin
      state <= state_nxt;
      ic    <= ic_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ic_nxt    = ic;
    if (clr) begin
      state_nxt = INIT;
      ic_nxt    = '0;
    end else if (state == INIT) begin
      if (ic == IC_LAST) begin
        state_nxt = RUN;
        ic_nxt    = '0;
      end else begin
        ic_nxt = ic + addr_width'(1);
      end
    end
  end

  assign run       = (state == RUN);
  assign init_busy = ~reset_n | (state == INIT);
  assign wr_ok     = run & bus.we & ({1'b0, bus.wa} < DEPTH_L);

  // The array itself carries no reset; the init sequencer is what gives it a known state.
  always_ff @(posedge clk) begin
    if (!run) begin
      ram[ic] <= init_value;
    end else if (wr_ok) begin
      for (int j = 0; j < lanes; j++) begin
        if (bus.wbe[j]) ram[bus.wa][j*LW +: LW] <= bus.wd[j*LW +: LW];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < nrd; i++) begin
      rdat[i] = init_value;
      if ({1'b0, ra_a[i]} < DEPTH_L) rdat[i] = ram[ra_a[i]];
      // Forwarding merges only the lanes being written this cycle.
      if (bypass != 0 && wr_ok && bus.wa == ra_a[i]) begin
        for (int j = 0; j < lanes; j++) begin
          if (bus.wbe[j]) rdat[i][j*LW +: LW] = bus.wd[j*LW +: LW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < rlat; k++) begin
        pv[k] <= '0;
        for (int i = 0; i < nrd; i++) pd[k][i] <= '0;
      end
    end else begin
      pv[0] <= run ? bus.re : '0;
      for (int i = 0; i < nrd; i++) begin
        if (run && bus.re[i]) pd[0][i] <= rdat[i];
      end
      // Each stage loads only behind a valid, so the last stage holds the last returned data.
      for (int k = 1; k < rlat; k++) begin
        pv[k] <= pv[k-1];
        for (int i = 0; i < nrd; i++) begin
          if (pv[k-1][i]) pd[k][i] <= pd[k-1][i];
        end
      end
    end
  end

  for (genvar g = 0; g < nrd; g++) begin : g_port
    assign ra_a[g]                 = bus.ra[g*addr_width +: addr_width];
    assign bus.rd[g*width +: width] = pd[rlat-1][g];
  end

  assign bus.rv = pv[rlat-1];

endmodule

// File: tb/tb_base_mem_mrp.sv
`timescale 1ns/1ps
// Bench: two base_mem_mrp configurations driven from a vector table, reads checked via a scoreboard.
module tb_base_mem_mrp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic clr0, clr1;
  logic busy0, busy1;

  base_mem_mrp_if #(.width(16), .addr_width(4), .lanes(2), .nrd(2)) bus0 ();
  base_mem_mrp_if #(.width(8),  .addr_width(4), .lanes(1), .nrd(2)) bus1 ();

  base_mem_mrp #(
    .width(16), .addr_width(4), .depth(16), .lanes(2), .nrd(2),
    .rlat(1), .bypass(1), .init_value(16'h0000)
  ) dut0 (.clk(clk), .reset_n(reset_n), .clr(clr0), .init_busy(busy0), .bus(bus0));

  base_mem_mrp #(
    .width(8), .addr_width(4), .depth(10), .lanes(1), .nrd(2),
    .rlat(3), .bypass(0), .init_value(8'h3C)
  ) dut1 (.clk(clk), .reset_n(reset_n), .clr(clr1), .init_busy(busy1), .bus(bus1));

  typedef struct {
    int          dut;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [1:0]  wbe;
    logic [1:0]  re;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  exp_t  sbq [4][$];
  exp_t  em;
  vec_t  tbl [$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    mon_en = 1'b1;

  logic [3:0]  rv_all;
  logic [15:0] rd_all [4];
  assign rv_all    = {bus1.rv, bus0.rv};
  assign rd_all[0] = bus0.rd[15:0];
  assign rd_all[1] = bus0.rd[31:16];
  assign rd_all[2] = {8'h00, bus1.rd[7:0]};
  assign rd_all[3] = {8'h00, bus1.rd[15:8]};

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every rv must match the oldest outstanding read of that port, on its due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int p = 0; p < 4; p++) begin
        while (sbq[p].size() > 0 && sbq[p][0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_rv port%0d: no rv by cycle %0d, required data %h", p, sbq[p][0].due, sbq[p][0].d);
          sbq[p].delete(0);
        end
        if (rv_all[p]) begin
          checks++;
          if (sbq[p].size() == 0) begin
            errors++;
            $display("FAIL unexpected_rv port%0d: rv with rd=%h at cycle %0d, required no rv", p, rd_all[p], cyc);
          end else begin
            em = sbq[p].pop_front();
            if (rd_all[p] !== em.d || cyc != em.due) begin
              errors++;
              $display("FAIL read port%0d: rd=%h at cycle %0d, required %h at cycle %0d", p, rd_all[p], cyc, em.d, em.due);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus0.we = 1'b0; bus0.wa = '0; bus0.wd = '0; bus0.wbe = '0; bus0.re = '0; bus0.ra = '0;
    bus1.we = 1'b0; bus1.wa = '0; bus1.wd = '0; bus1.wbe = '0; bus1.re = '0; bus1.ra = '0;
  endtask

  function automatic vec_t mk(input int dut, input logic we, input logic [3:0] wa, input logic [15:0] wd,
                              input logic [1:0] wbe, input logic [1:0] re, input logic [3:0] ra0,
                              input logic [3:0] ra1, input logic [15:0] e0, input logic [15:0] e1);
    vec_t v;
    v.dut = dut; v.we = we; v.wa = wa; v.wd = wd; v.wbe = wbe;
    v.re = re; v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  // One vector per cycle; expected data is due rlat cycles after the driving cycle.
  task automatic apply(input vec_t v);
    exp_t x;
    if (v.dut == 0) begin
      bus0.we = v.we; bus0.wa = v.wa; bus0.wd = v.wd; bus0.wbe = v.wbe;
      bus0.re = v.re; bus0.ra = {v.ra1, v.ra0};
      if (v.re[0]) begin x.d = v.e0; x.due = cyc + 1; sbq[0].push_back(x); end
      if (v.re[1]) begin x.d = v.e1; x.due = cyc + 1; sbq[1].push_back(x); end
    end else begin
      bus1.we = v.we; bus1.wa = v.wa; bus1.wd = v.wd[7:0]; bus1.wbe = v.wbe[0:0];
      bus1.re = v.re; bus1.ra = {v.ra1, v.ra0};
      if (v.re[0]) begin x.d = v.e0; x.due = cyc + 3; sbq[2].push_back(x); end
      if (v.re[1]) begin x.d = v.e1; x.due = cyc + 3; sbq[3].push_back(x); end
    end
    tick();
    idle_all();
  endtask

  task automatic count_busy0(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy0) n++;
      else break;
    end
  endtask

  initial begin
    int n0, n1, pending;

    // dut0: 16-bit, 2 lanes, rlat 1, forwarding on, init 0
    tbl.push_back(mk(0, 1, 3, 16'hABCD, 2'b01, 2'b00, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 2'b00, 2'b11, 3, 3, 16'h00CD, 16'h00CD));
    tbl.push_back(mk(0, 1, 3, 16'h1200, 2'b10, 2'b00, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 2'b00, 2'b11, 3, 4, 16'h12CD, 16'h0000));
    tbl.push_back(mk(0, 1, 5, 16'h005A, 2'b11, 2'b11, 5, 5, 16'h005A, 16'h005A));
    tbl.push_back(mk(0, 1, 5, 16'hBBCC, 2'b10, 2'b11, 5, 3, 16'hBB5A, 16'h12CD));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 2'b00, 2'b11, 7, 5, 16'h0000, 16'hBB5A));
    tbl.push_back(mk(0, 1, 7, 16'h00FF, 2'b11, 2'b01, 7, 0, 16'h00FF, 16'h0000));
    tbl.push_back(mk(0, 1, 7, 16'h1111, 2'b00, 2'b10, 0, 7, 16'h0000, 16'h00FF));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 2'b00, 2'b01, 7, 0, 16'h00FF, 16'h0000));
    // dut1: 8-bit, depth 10, rlat 3, no forwarding, init 3C
    tbl.push_back(mk(1, 1, 0, 16'h000A, 2'b01, 2'b00, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 1, 1, 16'h000B, 2'b01, 2'b00, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 1, 2, 16'h000C, 2'b01, 2'b00, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 2'b00, 2'b10, 0, 0, 16'h0000, 16'h000A));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 2'b00, 2'b10, 0, 1, 16'h0000, 16'h000B));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 2'b00, 2'b10, 0, 2, 16'h0000, 16'h000C));
    tbl.push_back(mk(1, 1, 5, 16'h005A, 2'b01, 2'b11, 5, 5, 16'h003C, 16'h003C));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 2'b00, 2'b01, 5, 0, 16'h005A, 16'h0000));
    tbl.push_back(mk(1, 1, 12, 16'h0077, 2'b01, 2'b01, 12, 0, 16'h003C, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 2'b00, 2'b11, 12, 2, 16'h003C, 16'h000C));
    tbl.push_back(mk(1, 1, 9, 16'h0099, 2'b01, 2'b00, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 2'b00, 2'b11, 10, 9, 16'h003C, 16'h0099));

    idle_all();
    clr0 = 1'b0;
    clr1 = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_busy0", 32'(busy0), 32'd1);
    chk("reset_busy1", 32'(busy1), 32'd1);
    chk("reset_rv0", 32'(bus0.rv), 32'd0);
    chk("reset_rv1", 32'(bus1.rv), 32'd0);
    chk("reset_rd0", bus0.rd, 32'd0);
    chk("reset_rd1", 32'(bus1.rd), 32'd0);

    reset_n = 1'b1;
    n0 = 0;
    n1 = 0;
    repeat (30) begin
      @(negedge clk);
      n0 += int'(busy0);
      n1 += int'(busy1);
    end
    chk("init_len0", n0, 16);
    chk("init_len1", n1, 10);
    tick();

    for (int i = 0; i < 16; i++)
      apply(mk(0, 0, 0, 16'h0, 2'b00, 2'b11, 4'(i), 4'(15 - i), 16'h0000, 16'h0000));
    for (int i = 0; i < 12; i++)
      apply(mk(1, 0, 0, 16'h0, 2'b00, 2'b11, 4'(i), 4'(11 - i), 16'h003C, 16'h003C));

    foreach (tbl[i]) apply(tbl[i]);
    repeat (5) tick();

    // clr in RUN: writes/reads held active throughout init must be ignored
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    bus0.we = 1'b1; bus0.wa = 4'd7; bus0.wd = 16'hEEEE; bus0.wbe = 2'b11;
    bus0.re = 2'b11; bus0.ra = {4'd7, 4'd7};
    count_busy0(n0);
    idle_all();
    chk("clr_run_len", n0, 16);
    tick();
    apply(mk(0, 0, 0, 16'h0, 2'b00, 2'b11, 7, 3, 16'h0000, 16'h0000));
    apply(mk(0, 1, 9, 16'h9999, 2'b11, 2'b00, 0, 0, 16'h0000, 16'h0000));

    // clr again while the sequencer is at ic=9 restarts the full fill
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    repeat (9) tick();
    chk("busy_at_ic9", 32'(busy0), 32'd1);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    count_busy0(n0);
    chk("clr_restart_len", n0, 16);
    tick();
    apply(mk(0, 0, 0, 16'h0, 2'b00, 2'b11, 9, 0, 16'h0000, 16'h0000));
    repeat (5) tick();

    pending = 0;
    for (int p = 0; p < 4; p++) pending += sbq[p].size();
    chk("scoreboard_drained", pending, 0);

    // reset while a rlat=3 read is in flight drops it immediately
    bus1.re = 2'b01;
    bus1.ra = {4'd0, 4'd0};
    tick();
    idle_all();
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midreset_rv1", 32'(bus1.rv), 32'd0);
    chk("midreset_rd1", 32'(bus1.rd), 32'd0);
    chk("midreset_busy1", 32'(busy1), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("rv_in_reset", 32'(bus1.rv), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
